tlb_op_ctrl: RTL

- Sequences the TLB maintenance instructions (TLBP, TLBR, TLBWI) retiring in the WB stage.
- Holds WB while an op runs and drives the TLB search, read and write ports.
- Generates the CP0 update strobes for TLBP and TLBR.
- After TLBR or TLBWI, issues a refetch redirect to pc+4 so that younger instructions are re-translated under the new mapping.

---
 rtl/tlb_op_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP / TLBR / TLBWI retiring in WB.
// Holds WB while an op runs, drives the TLB search/read/write ports,
// produces the CP0 update strobes, and requests a refetch of pc+4 after
// TLBR/TLBWI so younger instructions are re-translated.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    input  logic [31:0]     op_pc,
    input  logic            ex_flush,
    input  logic [IDXW-1:0] c0_index,
    input  logic            s_found,
    input  logic [IDXW-1:0] s_index,
    input  logic            refetch_ack,
    output logic            op_done,
    output logic            wb_stall,
    output logic            s_req,
    output logic            tlb_re,
    output logic [IDXW-1:0] r_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] w_index,
    output logic            tlbp_wr,
    output logic            tlbp_found,
    output logic [IDXW-1:0] tlbp_index,
    output logic            tlbr_wr,
    output logic            refetch_valid,
    output logic [31:0]     refetch_pc,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SRCH = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_RFCH = 3'd4
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_pc;
    logic [IDXW-1:0] r_idx;
    logic            w_accept;
    logic            w_live;

    // The state itself encodes which op is running, so only pc and index
    // need to be captured at accept time.
    assign w_accept = (r_state == S_IDLE) && op_valid && !ex_flush && (op_type != 2'b00);
    // A WB flush squashes every side effect of the current cycle.
    assign w_live   = !ex_flush;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the op's pc and CP0 index when it is accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_pc  <= op_pc;
            r_idx <= c0_index;
        end
    end

    // Next-state logic; a flush in any busy state returns to IDLE.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_type)
                        OP_TLBP:  w_next = S_SRCH;
                        OP_TLBR:  w_next = S_RD;
                        OP_TLBWI: w_next = S_WR;
                        default:  w_next = S_IDLE;
                    endcase
                end
            end
            S_SRCH:  w_next = S_IDLE;
            S_RD:    w_next = S_RFCH;
            S_WR:    w_next = S_RFCH;
            S_RFCH:  if (refetch_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (ex_flush) begin
            w_next = S_IDLE;
        end
    end

    // Output decode per state, with strobes masked by a same-cycle flush.
    always_comb begin
        op_done       = 1'b0;
        s_req         = 1'b0;
        tlb_re        = 1'b0;
        r_index       = '0;
        tlb_we        = 1'b0;
        w_index       = '0;
        tlbp_wr       = 1'b0;
        tlbp_found    = 1'b0;
        tlbp_index    = '0;
        tlbr_wr       = 1'b0;
        refetch_valid = 1'b0;
        refetch_pc    = '0;
        case (r_state)
            S_SRCH: begin
                s_req      = 1'b1;
                tlbp_wr    = w_live;
                tlbp_found = s_found;
                tlbp_index = s_found ? s_index : '0;
                op_done    = w_live;
            end
            S_RD: begin
                tlb_re  = w_live;
                r_index = r_idx;
                tlbr_wr = w_live;
            end
            S_WR: begin
                tlb_we  = w_live;
                w_index = r_idx;
            end
            S_RFCH: begin
                refetch_valid = w_live;
                refetch_pc    = r_pc + 32'd4;
                op_done       = w_live && refetch_ack;
            end
            default: ;
        endcase
    end

    assign wb_stall = op_valid && !op_done;
    assign busy     = (r_state != S_IDLE);

endmodule
